// File: rtl/demux8_stream.sv
// demux8_stream: 1-to-8 routing demultiplexer for a valid/ready stream.
//
// Each accepted word carries a 3-bit destination tag and is delivered to
// exactly one of eight consumer channels. Storage is a main register plus
// a skid register, so the block sustains one word per cycle. Words leave
// in the order they were accepted, and all outputs come from registers.
// A stalled head word blocks every later word, whichever channel it targets.
//
// Parameters:
//   WIDTH      data word width in bits
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   producer has a word
//   in_ready   block can accept a word this cycle
//   in_data    word to route
//   in_sel     destination channel 0..7, sampled on accept
//   out_valid  one-hot; bit i set means channel i holds the head word
//   out_ready  per-channel accept; only the addressed bit matters
//   out_data   head word, shared by all channels
//   occupancy  number of buffered words (0..2)
// Optional build macro DEMUX8_STREAM_STATS_EN adds:
//   stat_sel   selects one of the eight delivery counters
//   stat_count 16-bit wrapping count of pops delivered to that channel
module demux8_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef DEMUX8_STREAM_STATS_EN
    input  logic [2:0]       stat_sel,
    output logic [15:0]      stat_count,
`endif
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_data;
    logic [2:0]       main_sel;
    logic [WIDTH-1:0] skid_data;
    logic [2:0]       skid_sel;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             pop;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Entry validity follows directly from the occupancy state.
    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == TWO);

    assign in_ready  = ~skid_valid & ~rst;
    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready[main_sel];
    assign out_valid = main_valid ? (8'b1 << main_sel) : 8'h00;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    // Head leaves and the new word takes its place.
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Data registers are cleared on reset so out_data reads 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            main_sel  <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_sel  <= in_sel;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_sel  <= skid_sel;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_sel  <= in_sel;
            end
        end
    end

`ifdef DEMUX8_STREAM_STATS_EN
    logic [15:0] stat_cnt [8];

    // One wrapping delivery counter per channel, bumped on each pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                stat_cnt[i] <= 16'h0000;
            end
        end else if (pop) begin
            stat_cnt[main_sel] <= stat_cnt[main_sel] + 16'h0001;
        end
    end

    assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: doc/demux8_stream.md
Name: demux8_stream

Overview:
- 1-to-8 routing demultiplexer: the distribution counterpart of the 8-way select mux.
- Takes one valid/ready stream tagged with a 3-bit destination and delivers each word to exactly one of 8 consumer channels, e.g. steering datapath results to write-back or peripheral ports.
- Registered, 2-entry (main + skid) buffer: full throughput, order preserved, all outputs registered.

Parameters:
- WIDTH, 8: data word width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  3  destination channel 0..7.
- out_valid  output  8  one-hot; bit i set means channel i holds a word.
- out_ready  input  8  bit i: consumer i accepts this cycle.
- out_data  output  WIDTH  data shared by all channels; meaningful only for the asserted out_valid bit.
- occupancy  output  2  words buffered: 0, 1 or 2.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - While rst = 1: main and skid entries are invalid, out_valid = 8'h00, out_data = 0, occupancy = 0, in_ready = 0.
  - in_ready goes to 1 in the first cycle after rst deasserts.
  - Reset mid-operation discards every buffered word without delivering it.
- Transfers:
  - Accept = in_valid & in_ready.
  - Pop = main_valid & out_ready[main_sel].
  - out_ready bits of non-addressed channels are ignored.
- Outputs:
  - out_valid = main_valid ? (8'b1 << main_sel) : 8'h00.
  - out_data = main_data.
  - in_ready = ~skid_valid & ~rst.
  - occupancy = main_valid + skid_valid.
- Buffer update per cycle (the state machine is EMPTY / ONE / TWO, by occupancy):
  - EMPTY, accept -> word to main, ONE. out_valid appears the next cycle (latency 1).
  - ONE, accept & pop -> new word replaces main, stays ONE (1 word/cycle sustained).
  - ONE, accept & no pop -> word to skid, TWO. in_ready drops the next cycle.
  - ONE, pop & no accept -> EMPTY.
  - TWO, pop -> skid moves to main, skid cleared, ONE. in_ready returns the next cycle.
  - TWO, no pop -> hold all state. No accept is possible.
  - No event -> hold state. out_valid and out_data are stable while stalled (valid never drops without a pop).
- Ordering:
  - Words leave in strict acceptance order regardless of channel.
  - A stalled channel blocks all later words (head-of-line blocking; by design).
- in_sel is sampled only on accept. in_data/in_sel values while in_valid = 0 have no effect.
- Same channel back-to-back: the bit stays asserted; each cycle with out_ready is one delivery.
- Channel change: the one-hot bit moves in the same cycle main reloads.

Optional Feature:
- Macro: DEMUX8_STREAM_STATS_EN.
- When defined, the block adds:
  - Port stat_sel (input, 3 bits).
  - Port stat_count (output, 16 bits, combinational read of the selected counter).
  - Eight 16-bit counters, one per channel. Counter i increments on each pop delivered to channel i and wraps from 16'hFFFF to 16'h0000.
  - Counters clear on rst.
- When undefined: no extra ports, no counter logic; the remaining behaviour is identical.

Test Plan:
- Reset check:
  - Stimulus: assert rst mid-stream with 2 words buffered.
  - Response: out_valid = 8'h00, occupancy = 0 and in_ready = 0 immediately (asynchronous); in_ready = 1 the first cycle after release; dropped words never appear.
- Streaming:
  - Stimulus: out_ready = 8'hFF; send words 0x11..0x18 with in_sel = 0..7 on consecutive cycles.
  - Response: out_valid = 0x01, 0x02, ... 0x80 on consecutive cycles, each 1 cycle after its accept, with out_data matching; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready = 0; send 0xA5 to ch 3, then 0x5A to ch 6, then a third word.
  - Response: occupancy reaches 2 and in_ready = 0; out_valid holds 0x08 with 0xA5 stable.
  - Then set out_ready[3] = 1: the next cycle shows out_valid = 0x40 with 0x5A and in_ready = 1.
- Wrong-channel ready:
  - Stimulus: word to ch 2, out_ready = 8'hFB.
  - Response: no pop, occupancy stays 1, word is held indefinitely.
- Simultaneous accept and pop:
  - Stimulus: ONE state, pop on ch 1 while accepting a new word for ch 1.
  - Response: occupancy stays 1; out_valid[1] stays high; data updates to the new word.
- Stats (macro defined):
  - Stimulus: 3 pops to ch 5; separately preload ch 0 to 16'hFFFF, then 1 pop to ch 0.
  - Response: stat_sel = 5 reads 3; ch 0 wraps to 0.
